// File: rtl/borrow_lookahead_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : borrow_lookahead_subtractor
//  Description : Two-stage pipelined 8-bit subtractor, Diff = A - B - Bin.
//                Stage 1 resolves the low nibble with a 4-bit borrow
//                lookahead. Stage 2 resolves the high nibble from the
//                registered borrow b[4]. A valid/ready handshake sits on
//                both ends of the pipeline.
//  Options     : OVF_FLAG_EN - when defined, adds the signed-overflow
//                output V, registered alongside Diff.
//  Revision    : 1.0 - initial release
// ============================================================================
module borrow_lookahead_subtractor (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] Diff,
`ifdef OVF_FLAG_EN
    output logic       V,
`endif
    output logic       Bout
);

    // ------------------------------------------------------------------
    // 4-bit borrow lookahead: returns {borrow_out, diff[3:0]}.
    // Generate means this bit borrows by itself (a=0, b=1). Propagate
    // means this bit passes the incoming borrow on unchanged (a == b).
    // Every internal borrow is flattened into a sum of products, so no
    // borrow ripples from one bit to the next.
    // ------------------------------------------------------------------
    function automatic logic [4:0] bla4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       bin
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] bw;
        g     = ~a & b;
        p     = ~(a ^ b);
        bw[0] = bin;
        bw[1] = g[0]
              | (p[0] & bin);
        bw[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & bin);
        bw[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bin);
        bw[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bin);
        return {bw[4], a ^ b ^ bw[3:0]};
    endfunction

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    // Stage 1: low-nibble result, borrow into bit 4, and the raw high
    // nibbles. A[7] and B[7] ride in a_hi_q[3] and b_hi_q[3], and the
    // overflow flag reads them from there.
    logic       s1_valid_q, s1_valid_d;
    logic [3:0] diff_lo_q,  diff_lo_d;
    logic       b4_q,       b4_d;
    logic [3:0] a_hi_q,     a_hi_d;
    logic [3:0] b_hi_q,     b_hi_d;

    // Stage 2: full result.
    logic       s2_valid_q, s2_valid_d;
    logic [7:0] diff_q,     diff_d;
    logic       bout_q,     bout_d;
`ifdef OVF_FLAG_EN
    logic       v_q,        v_d;
`endif

    // ------------------------------------------------------------------
    // Handshake / load enables
    // ------------------------------------------------------------------
    logic       s2_load;
    logic       s1_load;
    logic       in_xfer;
    logic [4:0] lo_res;
    logic [4:0] hi_res;

    // Stage 2 can take stage 1's content when it is empty or when its
    // own content leaves this cycle. Stage 1 can accept when it is empty
    // or when it empties into stage 2 on the same edge. This lets a full
    // pipeline shift by one stage without a bubble.
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load && !rst;
    assign in_xfer  = in_valid && in_ready;

    // Arithmetic for each nibble.
    assign lo_res = bla4(A[3:0], B[3:0], Bin);
    assign hi_res = bla4(a_hi_q, b_hi_q, b4_q);

    // Next-state for stage 1. Data moves only on a real input transfer,
    // so an idle stage keeps its old contents.
    always_comb begin
        s1_valid_d = s1_valid_q;
        diff_lo_d  = diff_lo_q;
        b4_d       = b4_q;
        a_hi_d     = a_hi_q;
        b_hi_d     = b_hi_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
        end
        if (in_xfer) begin
            diff_lo_d = lo_res[3:0];
            b4_d      = lo_res[4];
            a_hi_d    = A[7:4];
            b_hi_d    = B[7:4];
        end
    end

    // Next-state for stage 2. The high nibble completes here from the
    // registered operands and borrow.
    always_comb begin
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
`ifdef OVF_FLAG_EN
        v_d        = v_q;
`endif
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                diff_d = {hi_res[3:0], diff_lo_q};
                bout_d = hi_res[4];
`ifdef OVF_FLAG_EN
                // Signed overflow: operand signs differ and the result
                // sign differs from the minuend sign.
                v_d    = (a_hi_q[3] ^ b_hi_q[3]) & (hi_res[3] ^ a_hi_q[3]);
`endif
            end
        end
    end

    // Stage 1 register. Asynchronous reset empties the stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            diff_lo_q  <= 4'h0;
            b4_q       <= 1'b0;
            a_hi_q     <= 4'h0;
            b_hi_q     <= 4'h0;
        end else begin
            s1_valid_q <= s1_valid_d;
            diff_lo_q  <= diff_lo_d;
            b4_q       <= b4_d;
            a_hi_q     <= a_hi_d;
            b_hi_q     <= b_hi_d;
        end
    end

    // Stage 2 register. Asynchronous reset discards in-flight results and
    // clears the visible outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            diff_q     <= 8'h00;
            bout_q     <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
        end
    end

`ifdef OVF_FLAG_EN
    // Overflow flag register, kept in step with diff_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

    assign V = v_q;
`endif

    // Outputs come straight from stage-2 flops.
    assign out_valid = s2_valid_q;
    assign Diff      = diff_q;
    assign Bout      = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_borrow_lookahead_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_borrow_lookahead_subtractor
//  Description : Directed self-checking bench for borrow_lookahead_subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_borrow_lookahead_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic       Bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] Diff;
    logic       Bout;
`ifdef OVF_FLAG_EN
    logic       V;
`endif

    int vectors    = 0;
    int miscompares = 0;

    borrow_lookahead_subtractor dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
`ifdef OVF_FLAG_EN
        .V         (V),
`endif
        .Bout      (Bout)
    );

    always #5 clk = ~clk;

    // Operand driver only; it performs no checking.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic vld);
        A        = a;
        B        = b;
        Bin      = bin;
        in_valid = vld;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || Diff !== 8'h00 || Bout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b Diff=%h Bout=%b, want 0 0 00 0",
                     out_valid, in_ready, Diff, Bout);
        end
`ifdef OVF_FLAG_EN
        vectors++;
        if (V !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_V: got %b want 0", V);
        end
`endif
        drive(8'h12, 8'h01, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    // Single directed sets, out_ready held high.
    task automatic test_directed();
        logic [7:0] ta [8];
        logic [7:0] tb [8];
        logic       tbi[8];
        logic [7:0] ed [8];
        logic       eb [8];
        logic       ev [8];
        ta[0]=8'h10; tb[0]=8'h01; tbi[0]=0; ed[0]=8'h0F; eb[0]=0; ev[0]=0;
        ta[1]=8'h00; tb[1]=8'h01; tbi[1]=0; ed[1]=8'hFF; eb[1]=1; ev[1]=0;
        ta[2]=8'h55; tb[2]=8'h55; tbi[2]=1; ed[2]=8'hFF; eb[2]=1; ev[2]=0;
        ta[3]=8'h80; tb[3]=8'h01; tbi[3]=0; ed[3]=8'h7F; eb[3]=0; ev[3]=1;
        ta[4]=8'hFF; tb[4]=8'hFF; tbi[4]=0; ed[4]=8'h00; eb[4]=0; ev[4]=0;
        ta[5]=8'h00; tb[5]=8'hFF; tbi[5]=1; ed[5]=8'h00; eb[5]=1; ev[5]=0;
        ta[6]=8'h10; tb[6]=8'h00; tbi[6]=1; ed[6]=8'h0F; eb[6]=0; ev[6]=0;
        ta[7]=8'h7F; tb[7]=8'hFF; tbi[7]=0; ed[7]=8'h80; eb[7]=1; ev[7]=1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(ta[i], tb[i], tbi[i], 1'b1);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL directed_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            @(negedge clk);
            drive(8'h00, 8'h00, 1'b0, 1'b0);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL directed_latency1[%0d]: out_valid=%b want 0", i, out_valid);
            end
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || Diff !== ed[i] || Bout !== eb[i]) begin
                miscompares++;
                $display("FAIL directed[%0d] %h-%h-%b: out_valid=%b Diff=%h Bout=%b want 1 %h %b",
                         i, ta[i], tb[i], tbi[i], out_valid, Diff, Bout, ed[i], eb[i]);
            end
`ifdef OVF_FLAG_EN
            vectors++;
            if (V !== ev[i]) begin
                miscompares++;
                $display("FAIL directed_V[%0d]: got %b want %b", i, V, ev[i]);
            end
`endif
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0] sa[4];
        logic [7:0] ex[4];
        logic [7:0] got[$];
        int k;
        sa[0]=8'h09; sa[1]=8'h08; sa[2]=8'h07; sa[3]=8'h06;
        ex[0]=8'h08; ex[1]=8'h07; ex[2]=8'h06; ex[3]=8'h05;
        k = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (k < 4) drive(sa[k], 8'h01, 1'b0, 1'b1);
            #1;
            if (in_valid && in_ready) k++;
        end
        vectors++;
        if (k !== 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || Diff !== 8'h08) begin
            miscompares++;
            $display("FAIL bp_stall: accepted=%0d in_ready=%b out_valid=%b Diff=%h want 2 0 1 08",
                     k, in_ready, out_valid, Diff);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (out_valid) got.push_back(Diff);
            if (k < 4) drive(sa[k], 8'h01, 1'b0, 1'b1);
            else       drive(8'h00, 8'h00, 1'b0, 1'b0);
            #1;
            if (in_valid && in_ready) k++;
            if (got.size() >= 4 && k >= 4) break;
        end
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (got.size() != 4 || k != 4) begin
            miscompares++;
            $display("FAIL bp_count: results=%0d accepted=%0d want 4 4", got.size(), k);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= got.size()) begin
                miscompares++;
                $display("FAIL bp_order[%0d]: missing, want %h", i, ex[i]);
            end else if (got[i] !== ex[i]) begin
                miscompares++;
                $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], ex[i]);
            end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: out_valid=%b want 0 (duplicate result)", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] q[$];
        logic [9:0] e;
        logic [8:0] r;
        logic [7:0] a, b;
        logic       bi;
        int sent, rcv;
        sent = 0;
        rcv  = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && rcv < 256; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_spurious: Diff=%h with nothing outstanding", Diff);
                end else begin
                    e = q.pop_front();
`ifdef OVF_FLAG_EN
                    if (Diff !== e[7:0] || Bout !== e[8] || V !== e[9]) begin
                        miscompares++;
                        $display("FAIL stream[%0d]: Diff=%h Bout=%b V=%b want %h %b %b",
                                 rcv, Diff, Bout, V, e[7:0], e[8], e[9]);
                    end
`else
                    if (Diff !== e[7:0] || Bout !== e[8]) begin
                        miscompares++;
                        $display("FAIL stream[%0d]: Diff=%h Bout=%b want %h %b",
                                 rcv, Diff, Bout, e[7:0], e[8]);
                    end
`endif
                end
                rcv++;
            end else if (cyc >= 2) begin
                vectors++;
                miscompares++;
                $display("FAIL stream_throughput: bubble at cycle %0d, out_valid=%b want 1", cyc, out_valid);
            end
            if (sent < 256) begin
                a  = 8'($urandom_range(0, 255));
                b  = 8'($urandom_range(0, 255));
                bi = 1'($urandom_range(0, 1));
                drive(a, b, bi, 1'b1);
                r = {1'b0, a} - {1'b0, b} - {8'h00, bi};
                q.push_back({(a[7] ^ b[7]) & (r[7] ^ a[7]), r[8], r[7:0]});
                sent++;
                #1;
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_in_ready: set %0d in_ready=%b want 1", sent, in_ready);
                end
            end else begin
                drive(8'h00, 8'h00, 1'b0, 1'b0);
            end
        end
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (rcv != 256) begin
            miscompares++;
            $display("FAIL stream_count: got %0d results want 256", rcv);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        @(negedge clk);
        drive(8'h20, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        drive(8'h30, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_full: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || Diff !== 8'h00) begin
            miscompares++;
            $display("FAIL midrst_async: out_valid=%b in_ready=%b Diff=%h want 0 0 00",
                     out_valid, in_ready, Diff);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(8'h03, 8'h02, 1'b0, 1'b1);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        drive(8'h00, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_latency1: out_valid=%b want 0 (stale result)", out_valid);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || Diff !== 8'h01 || Bout !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_result: out_valid=%b Diff=%h Bout=%b want 1 01 0",
                     out_valid, Diff, Bout);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
